// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with valid/ready handshake, flush and optional skid entry
module pipe_stage_reg #(
    parameter int DBITS     = 32,
    parameter int CTRL_BITS = 4,
    parameter int SKID      = 1,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTRL_BITS-1:0] in_ctrl,
    input  logic [DBITS-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_BITS-1:0] out_ctrl,
    output logic [DBITS-1:0]     out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_BITS-1:0]  stall_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam bit HAS_SKID = (SKID != 0);
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    state_t               state;
    state_t               next;
    logic                 m_valid;
    logic                 s_valid;
    logic                 acc;
    logic                 pop;
    logic                 load_m;
    logic                 load_m_from_s;
    logic                 load_s;
    logic [CTRL_BITS-1:0] m_ctrl;
    logic [CTRL_BITS-1:0] s_ctrl;
    logic [DBITS-1:0]     m_data;
    logic [DBITS-1:0]     s_data;

    // Entry valid bits are encoded by the state: M valid unless EMPTY, S valid only in FULL.
    assign m_valid = (state != EMPTY);
    assign s_valid = (state == FULL);

    // With the skid entry, in_ready depends only on held state, never on out_ready.
    assign in_ready = (HAS_SKID ? !s_valid : (!m_valid || out_ready)) && !flush && !reset;
    assign acc      = in_valid && in_ready;
    assign pop      = m_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next          = state;
        load_m        = 1'b0;
        load_m_from_s = 1'b0;
        load_s        = 1'b0;
        if (flush) begin
            next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        load_m = 1'b1;
                        next   = ONE;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        load_m = 1'b1;
                    end else if (acc && HAS_SKID) begin
                        load_s = 1'b1;
                        next   = FULL;
                    end else if (pop) begin
                        next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        load_m_from_s = 1'b1;
                        next          = ONE;
                    end
                end
                default: next = EMPTY;
            endcase
        end
    end

    // Flush clears control bits but leaves data registers untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctrl <= '0;
            m_data <= '0;
        end else if (flush) begin
            m_ctrl <= '0;
        end else if (load_m) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
        end else if (load_m_from_s) begin
            m_ctrl <= s_ctrl;
            m_data <= s_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_ctrl <= '0;
            s_data <= '0;
        end else if (flush) begin
            s_ctrl <= '0;
        end else if (load_s) begin
            s_ctrl <= in_ctrl;
            s_data <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign out_data  = m_data;
    assign occupancy = s_valid ? 2'd2 : (m_valid ? 2'd1 : 2'd0);

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register with valid/ready handshake, synchronous flush and an optional two-entry skid buffer.
- Successor to the fixed execute-to-memory split register.
- Carries a control bundle (regWrite, memWrite, memtoReg, jal and similar) and a data bundle (aluOut, sr2Out, incrementedPC and similar) between processor stages.
- Adds stall, flush, bubble insertion and a stall-cycle counter.

Parameters:
- DBITS, 32: width of in_data/out_data.
- CTRL_BITS, 4: width of in_ctrl/out_ctrl. Forced to 0 whenever the stage holds no valid entry.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_BITS, 16: width of the stall-cycle counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush; invalidates all held entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept an entry this cycle.
- in_ctrl  input  CTRL_BITS  upstream control bundle.
- in_data  input  DBITS  upstream data bundle.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head entry.
- out_ctrl  output  CTRL_BITS  head control bundle; 0 when out_valid=0.
- out_data  output  DBITS  head data bundle.
- occupancy  output  2  number of held entries (0..2).
- stall_cnt  output  CNT_BITS  saturating count of stalled cycles.

Behaviour:
- Storage
  - Main entry M (valid, ctrl, data) and skid entry S (valid, ctrl, data). S exists only when SKID=1.
  - out_valid=M.valid; out_data=M.data; out_ctrl = M.valid ? M.ctrl : 0.
- Reset (asynchronous, reset=1)
  - M.valid=S.valid=0; all ctrl/data regs=0; stall_cnt=0.
  - Outputs during reset: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=0.
  - In-flight entries are discarded.
  - After reset deasserts: in_ready=1 from the first following cycle.
- Transfers
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
- SKID=1: in_ready = !S.valid & !flush & !reset. It is a registered-state function and does not depend on out_ready.
  - EMPTY (occupancy 0): acc -> M<=in, go to ONE.
  - ONE (occupancy 1):
    - acc & pop -> M<=in, stay in ONE.
    - acc & !pop -> S<=in, go to FULL.
    - !acc & pop -> EMPTY.
    - Otherwise hold.
  - FULL (occupancy 2): acc impossible. pop -> M<=S, S.valid<=0, go to ONE. Otherwise hold.
- SKID=0: in_ready = (!M.valid | out_ready) & !flush & !reset.
  - acc -> M<=in.
  - pop & !acc -> M.valid<=0.
  - occupancy is never 2.
- Latency: an entry accepted in cycle N is visible on out_* in cycle N+1 when the stage was empty.
- Ordering: strict FIFO; no entry is ever duplicated or reordered.
- Flush (highest priority after reset)
  - in_ready=0 in the flush cycle, so nothing is accepted.
  - A pop in the flush cycle counts as completed downstream.
  - Next cycle: M.valid=S.valid=0, M.ctrl=S.ctrl=0, data regs hold.
  - Next state is EMPTY.
  - flush held high for multiple cycles keeps the stage empty and in_ready=0.
- Stall counter
  - stall_cnt increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_BITS-1 with no wrap.
  - Cleared only by reset; flush does not clear it.
- Data regs load only on their own write (no X propagation). Unused S regs in SKID=0 are optimised away.

Test Plan:
- Reset, then hold out_ready=1 and stream in_data=0x00000001..0x00000008 with in_ctrl=0xF, one entry per cycle → out_data 1..8 in order, each one cycle after acceptance. in_ready stays 1; occupancy stays 1; stall_cnt=0.
- SKID=1 backpressure: out_ready=0, present A=0xAAAA0000 then B=0xBBBB0000 → occupancy 2 and in_ready=0 after B. Raise out_ready for 2 cycles → out A then B, occupancy returns to 0. stall_cnt equals the number of stalled cycles with out_valid=1.
- Flush while FULL (A, B held), out_ready=0 → next cycle out_valid=0, out_ctrl=0x0, occupancy=0. A concurrent in_valid entry C is not accepted (in_ready=0). C is accepted the following cycle.
- Assert reset asynchronously mid-cycle while occupancy=2 → out_valid, out_ctrl, occupancy and stall_cnt go to 0 immediately without waiting for a clock edge. First entry after release appears normally.
- CNT_BITS=4, out_valid=1, out_ready=0 for 20 cycles → stall_cnt saturates at 0xF and does not wrap.
- SKID=0, out_ready toggling 1,0,1,0 with in_valid=1 → in_ready tracks !M.valid | out_ready combinationally. No entry is lost; occupancy is never 2.
